// File: rtl/uart_cmd_tx.sv
// ---------------------------------------------------------------------------
// uart_cmd_tx
//
// Host-side command frame transmitter. A single handshake accepts one
// high-level command. The command is expanded into the byte sequence that
// the command decoder expects, and each byte is sent as a UART frame.
//
//   type 0 (reg write)      : 0xAA, addr, data_a
//   type 1 (reg read)       : 0xBB, addr
//   type 2 (ALU w/ operands): 0xCC, data_a, data_b, func
//   type 3 (ALU no operands): 0xDD, func
//
// Frame: start 0, data LSB first, optional parity, stop 1. Frames within a
// command are back-to-back.
//
// Ports
//   UART_CLK       in   bit-timing clock, rising edge
//   Reset          in   asynchronous active-low reset
//   Cmd_valid      in   command request
//   Cmd_ready      out  high only while idle; accept on Cmd_valid & Cmd_ready
//   Cmd_type       in   [1:0] command type (see above)
//   Cmd_addr       in   [width-1:0] register address
//   Cmd_data_a     in   [width-1:0] write data / operand A
//   Cmd_data_b     in   [width-1:0] operand B
//   Cmd_func       in   [width-1:0] ALU function
//   Prescale       in   [5:0] clock cycles per bit, 0 behaves as 1
//   Parity_enable  in   insert parity bit (parity build only)
//   Parity_type    in   0 = even, 1 = odd (parity build only)
//   Tx_out         out  registered serial line, idle high
//   Busy           out  high while a command is on the line
//
// Configuration macro: UART_CMD_TX_PARITY_EN
//   defined   -> parity bit inserted when Parity_enable = 1 (11-bit frames)
//   undefined -> no parity logic, no PARITY state, 10-bit frames always
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_cmd_tx #(
  parameter int width = 8
) (
  input  logic             UART_CLK,
  input  logic             Reset,
  input  logic             Cmd_valid,
  output logic             Cmd_ready,
  input  logic [1:0]       Cmd_type,
  input  logic [width-1:0] Cmd_addr,
  input  logic [width-1:0] Cmd_data_a,
  input  logic [width-1:0] Cmd_data_b,
  input  logic [width-1:0] Cmd_func,
  input  logic [5:0]       Prescale,
  input  logic             Parity_enable,
  input  logic             Parity_type,
  output logic             Tx_out,
  output logic             Busy
);

  localparam int BIT_W = (width > 1) ? $clog2(width) : 1;

  localparam logic [width-1:0] HDR_WRITE   = width'(8'hAA);
  localparam logic [width-1:0] HDR_READ    = width'(8'hBB);
  localparam logic [width-1:0] HDR_ALU_OP  = width'(8'hCC);
  localparam logic [width-1:0] HDR_ALU_NOP = width'(8'hDD);

`ifdef UART_CMD_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  // State and counters
  state_t           r_state;
  logic [5:0]       r_tick;
  logic [BIT_W-1:0] r_bitIdx;
  logic [1:0]       r_byteIdx;
  logic [1:0]       r_lastByte;

  // Command latches, captured at acceptance
  logic [1:0]       r_type;
  logic [width-1:0] r_addr;
  logic [width-1:0] r_dataA;
  logic [width-1:0] r_dataB;
  logic [width-1:0] r_func;
  logic [5:0]       r_prescaleM1;
`ifdef UART_CMD_TX_PARITY_EN
  logic             r_parEn;
  logic             r_parOdd;
`endif

  // Registered outputs
  logic             r_tx;
  logic             r_busy;

  // Combinational next-state values
  state_t           w_stateNext;
  logic [5:0]       w_tickNext;
  logic [BIT_W-1:0] w_bitNext;
  logic [1:0]       w_byteNext;
  logic             w_txNext;
  logic             w_accept;
  logic             w_tickLast;
  logic [width-1:0] w_curByte;
  logic [1:0]       w_lastByteNew;
  logic [5:0]       w_prescaleM1New;
`ifdef UART_CMD_TX_PARITY_EN
  logic             w_parBit;
`else
  logic             w_unusedParity;
  assign w_unusedParity = Parity_enable ^ Parity_type;
`endif

  assign Cmd_ready  = (r_state == S_IDLE);
  assign w_accept   = Cmd_valid & Cmd_ready;
  assign w_tickLast = (r_tick == r_prescaleM1);
  assign Tx_out     = r_tx;
  assign Busy       = r_busy;

  // The counter compares against P-1, so a prescale of 0 is folded into 1
  // here rather than special-cased in the bit timing.
  assign w_prescaleM1New = (Prescale == 6'd0) ? 6'd0 : (Prescale - 6'd1);

  // Index of the final byte of each command type.
  always_comb begin
    w_lastByteNew = 2'd1;
    case (Cmd_type)
      2'd0:    w_lastByteNew = 2'd2;
      2'd1:    w_lastByteNew = 2'd1;
      2'd2:    w_lastByteNew = 2'd3;
      default: w_lastByteNew = 2'd1;
    endcase
  end

  // Byte currently on the line, selected from the latched command by the
  // byte index. The header byte is always index 0.
  always_comb begin
    w_curByte = '0;
    case (r_type)
      2'd0: begin
        case (r_byteIdx)
          2'd0:    w_curByte = HDR_WRITE;
          2'd1:    w_curByte = r_addr;
          default: w_curByte = r_dataA;
        endcase
      end
      2'd1: begin
        w_curByte = (r_byteIdx == 2'd0) ? HDR_READ : r_addr;
      end
      2'd2: begin
        case (r_byteIdx)
          2'd0:    w_curByte = HDR_ALU_OP;
          2'd1:    w_curByte = r_dataA;
          2'd2:    w_curByte = r_dataB;
          default: w_curByte = r_func;
        endcase
      end
      default: begin
        w_curByte = (r_byteIdx == 2'd0) ? HDR_ALU_NOP : r_func;
      end
    endcase
  end

`ifdef UART_CMD_TX_PARITY_EN
  // Even parity is the XOR of the data bits; odd parity inverts it.
  assign w_parBit = (^w_curByte) ^ r_parOdd;
`endif

  // Next-state logic. Every non-idle state lasts one bit time; transitions
  // only happen on the last tick of that bit time. STOP chains directly into
  // START of the next byte so frames inside a command have no idle gap.
  always_comb begin
    w_stateNext = r_state;
    w_tickNext  = r_tick;
    w_bitNext   = r_bitIdx;
    w_byteNext  = r_byteIdx;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_stateNext = S_START;
          w_tickNext  = 6'd0;
          w_bitNext   = '0;
          w_byteNext  = 2'd0;
        end
      end
      default: begin
        if (!w_tickLast) begin
          w_tickNext = r_tick + 6'd1;
        end else begin
          w_tickNext = 6'd0;
          case (r_state)
            S_START: begin
              w_stateNext = S_DATA;
              w_bitNext   = '0;
            end
            S_DATA: begin
              if (r_bitIdx == BIT_W'(width - 1)) begin
`ifdef UART_CMD_TX_PARITY_EN
                w_stateNext = r_parEn ? S_PARITY : S_STOP;
`else
                w_stateNext = S_STOP;
`endif
              end else begin
                w_bitNext = r_bitIdx + 1'b1;
              end
            end
`ifdef UART_CMD_TX_PARITY_EN
            S_PARITY: begin
              w_stateNext = S_STOP;
            end
`endif
            S_STOP: begin
              if (r_byteIdx == r_lastByte) begin
                w_stateNext = S_IDLE;
              end else begin
                w_stateNext = S_START;
                w_byteNext  = r_byteIdx + 2'd1;
              end
            end
            default: begin
              w_stateNext = S_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // Line value for the state being entered. Registering this value keeps
  // Tx_out glitch-free and aligned with the state register, so the start bit
  // appears on the edge that latches the command.
  always_comb begin
    w_txNext = 1'b1;
    case (w_stateNext)
      S_IDLE:   w_txNext = 1'b1;
      S_START:  w_txNext = 1'b0;
      S_DATA:   w_txNext = w_curByte[w_bitNext];
`ifdef UART_CMD_TX_PARITY_EN
      S_PARITY: w_txNext = w_parBit;
`endif
      S_STOP:   w_txNext = 1'b1;
      default:  w_txNext = 1'b1;
    endcase
  end

  // State, counters and output registers. Reset abandons any frame in
  // flight and returns the line to idle high immediately.
  always_ff @(posedge UART_CLK or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_tick    <= 6'd0;
      r_bitIdx  <= '0;
      r_byteIdx <= 2'd0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_tick    <= w_tickNext;
      r_bitIdx  <= w_bitNext;
      r_byteIdx <= w_byteNext;
      r_tx      <= w_txNext;
      r_busy    <= (w_stateNext != S_IDLE);
    end
  end

  // Command latches. Inputs are only sampled on the accepting edge, so the
  // host may change them freely while a command is being transmitted.
  always_ff @(posedge UART_CLK or negedge Reset) begin
    if (!Reset) begin
      r_type       <= 2'd0;
      r_addr       <= '0;
      r_dataA      <= '0;
      r_dataB      <= '0;
      r_func       <= '0;
      r_prescaleM1 <= 6'd0;
      r_lastByte   <= 2'd0;
`ifdef UART_CMD_TX_PARITY_EN
      r_parEn      <= 1'b0;
      r_parOdd     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_type       <= Cmd_type;
      r_addr       <= Cmd_addr;
      r_dataA      <= Cmd_data_a;
      r_dataB      <= Cmd_data_b;
      r_func       <= Cmd_func;
      r_prescaleM1 <= w_prescaleM1New;
      r_lastByte   <= w_lastByteNew;
`ifdef UART_CMD_TX_PARITY_EN
      r_parEn      <= Parity_enable;
      r_parOdd     <= Parity_type;
`endif
    end
  end

endmodule
